// File: rtl/loader_fsm.sv
// Boot-image loader: turns a byte stream (16-bit word count, then little-endian words) into IMEM writes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
//
// state  | meaning
// CNT_LO | waiting for low byte of word count
// CNT_HI | waiting for high byte of word count; validates N
// DATA   | assembling payload bytes into a word
// WRITE  | one-cycle IMEM write strobe, bumps words_loaded
// CHK    | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image loaded, sticky until reset
// ERROR  | image rejected, sticky until reset
module loader_fsm #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        loader_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_buf_q;
    logic        accept;
    logic        rdy_state;
    logic        last_word;
    logic [15:0] n_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept    = byte_valid & byte_ready;
    assign n_full    = {byte_data, count_q[7:0]};
    assign last_word = ({1'b0, words_loaded} + 17'd1) >= {1'b0, count_q};

    always_comb begin
        state_d   = state_q;
        rdy_state = 1'b0;
        case (state_q)
            CNT_LO: begin
                rdy_state = 1'b1;
                if (accept) state_d = CNT_HI;
            end
            CNT_HI: begin
                rdy_state = 1'b1;
                if (accept) begin
                    if (n_full == 16'd0)
                        state_d = DONE;
                    else if ({1'b0, n_full} > MAX_W)
                        state_d = ERROR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                rdy_state = 1'b1;
                if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                if (!last_word)
                    state_d = DATA;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                rdy_state = 1'b1;
                if (accept) state_d = (byte_data == csum_q) ? DONE : ERROR;
            end
`endif
            default: ;
        endcase
    end

    // Ready is masked by reset so nothing is offered while the loader is held.
    assign byte_ready  = rst & rdy_state;
    assign imem_we     = (state_q == WRITE);
    assign loader_done = (state_q == DONE);
    assign load_error  = (state_q == ERROR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CNT_LO;
            count_q      <= '0;
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
            imem_waddr   <= ADDR_BASE;
            imem_wdata   <= '0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                case (state_q)
                    CNT_LO: count_q[7:0] <= byte_data;
                    CNT_HI: count_q      <= n_full;
                    DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_data;
`endif
                        // Bytes shift in from the top, so the first byte ends up in [7:0].
                        if (byte_cnt_q == 2'd3) begin
                            imem_wdata <= {byte_data, word_buf_q};
                            imem_waddr <= ADDR_BASE + {14'd0, words_loaded, 2'b00};
                            byte_cnt_q <= 2'd0;
                        end else begin
                            word_buf_q <= {byte_data, word_buf_q[23:8]};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == WRITE) words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule

// File: tb/tb_loader_fsm.sv
// Directed bench for loader_fsm with hand-computed expected IMEM writes and status flags.
module tb_loader_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        loader_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    loader_fsm dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .loader_done(loader_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("send_timeout", 32'(n), 32'd0);
        end else begin
            @(posedge clk);
        end
        #1 byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic drive_ignored(input int cycles);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (cycles) @(negedge clk);
        byte_valid = 1'b0;
    endtask

    initial begin
        // Reset values while held
        #12;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", imem_waddr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_done", 32'(loader_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(byte_ready), 32'd1);

        // Two-word image
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        check("w0_we", 32'(imem_we), 32'd1);
        check("w0_addr", imem_waddr, 32'h0);
        check("w0_data", imem_wdata, 32'h00A00513);
        check("w0_ready_low", 32'(byte_ready), 32'd0);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        check("w1_we", 32'(imem_we), 32'd1);
        check("w1_done_early", 32'(loader_done), 32'd0);
        @(posedge clk); #1;
        check("two_done", 32'(loader_done), 32'd1);
        check("two_we_off", 32'(imem_we), 32'd0);
        check("two_words", 32'(words_loaded), 32'd2);
        check("two_addr_hold", imem_waddr, 32'h4);
        check("two_data_hold", imem_wdata, 32'h00100593);
        check("two_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("two_a0", wr_addr[0], 32'h0);
            check("two_d0", wr_data[0], 32'h00A00513);
            check("two_a1", wr_addr[1], 32'h4);
            check("two_d1", wr_data[1], 32'h00100593);
        end
        drive_ignored(4);
        check("done_ignore_writes", 32'(wr_addr.size()), 32'd2);
        check("done_ignore_words", 32'(words_loaded), 32'd2);
        check("done_sticky", 32'(loader_done), 32'd1);
        check("done_ready", 32'(byte_ready), 32'd0);

        do_reset();
        check("rst2_waddr", imem_waddr, 32'h0);
        check("rst2_words", 32'(words_loaded), 32'd0);
        check("rst2_done", 32'(loader_done), 32'd0);

        // Empty image
        send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1;
        check("zero_done", 32'(loader_done), 32'd1);
        check("zero_err", 32'(load_error), 32'd0);
        repeat (3) @(negedge clk);
        check("zero_nwrites", 32'(wr_addr.size()), 32'd0);

        // Oversized count
        do_reset();
        send_byte(8'h01); send_byte(8'h04);
        check("over_err", 32'(load_error), 32'd1);
        check("over_done", 32'(loader_done), 32'd0);
        drive_ignored(6);
        check("over_sticky", 32'(load_error), 32'd1);
        check("over_nwrites", 32'(wr_addr.size()), 32'd0);
        check("over_words", 32'(words_loaded), 32'd0);

        // Exactly MAX_WORDS is accepted
        do_reset();
        send_byte(8'h00); send_byte(8'h04);
        check("max_err", 32'(load_error), 32'd0);
        check("max_ready", 32'(byte_ready), 32'd1);

        // Stall between bytes 2 and 3
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        repeat (5) @(negedge clk);
        send_byte(8'hA0); send_byte(8'h00);
        check("stall_ready_write", 32'(byte_ready), 32'd0);
        check("stall_data", imem_wdata, 32'h00A00513);
`ifndef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        check("stall_done", 32'(loader_done), 32'd1);
`endif

        // Reset mid-load then a fresh one-word image
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifndef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        check("fresh_done", 32'(loader_done), 32'd1);
`endif
        check("fresh_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("fresh_addr", wr_addr[0], 32'h0);
            check("fresh_data", wr_data[0], 32'hDEADBEEF);
        end

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksum
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB6);
        check("csum_ok_done", 32'(loader_done), 32'd1);
        check("csum_ok_err", 32'(load_error), 32'd0);
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB7);
        check("csum_bad_err", 32'(load_error), 32'd1);
        check("csum_bad_done", 32'(loader_done), 32'd0);
        check("csum_bad_nwrites", 32'(wr_addr.size()), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
